wbscratchpad: RTL and testbench

//  Pipelined Wishbone responder that terminates a bus with an on-chip

---
 rtl/wbscratchpad.sv | 88 ++++++++
 tb/tb_wbscratchpad.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wbscratchpad.sv
// Pipelined Wishbone responder backed by a 2^LGMEM-word scratchpad RAM.
// Fixed DELAY response latency; at most MAXPEND requests in flight.
module wbscratchpad #(
    parameter int AW      = 30,
    parameter int DW      = 32,
    parameter int LGMEM   = 8,
    parameter int DELAY   = 2,
    parameter int MAXPEND = 2
) (
    input  logic            i_wb_clk,
    input  logic            i_reset_n,
    input  logic            i_wb_cyc,
    input  logic            i_wb_stb,
    input  logic            i_wb_we,
    input  logic [AW-1:0]   i_wb_addr,
    input  logic [DW-1:0]   i_wb_data,
    input  logic [DW/8-1:0] i_wb_sel,
    output logic            o_wb_stall,
    output logic            o_wb_ack,
    output logic [DW-1:0]   o_wb_data,
    output logic            o_wb_err
);
    localparam int NB = DW / 8;
    localparam int PW = $clog2(MAXPEND + 1);

    logic [DW-1:0]    r_mem [0:(1<<LGMEM)-1];
    logic [PW-1:0]    r_pend;
    logic [DELAY-1:0] r_vld_p;
    logic [DELAY-1:0] r_err_p;
    logic [DW-1:0]    r_dat_p [0:DELAY-1];

    logic             w_accept;
    logic             w_in_range;
    logic             w_retire;
    logic [LGMEM-1:0] w_idx;

    generate
        if (LGMEM < AW) begin : g_rng
            assign w_in_range = (i_wb_addr[AW-1:LGMEM] == '0);
        end else begin : g_full
            assign w_in_range = 1'b1;
        end
    endgenerate

    assign w_idx      = i_wb_addr[LGMEM-1:0];
    assign o_wb_stall = (r_pend == PW'(MAXPEND));
    assign w_accept   = i_reset_n && i_wb_cyc && i_wb_stb && !o_wb_stall;
    assign w_retire   = r_vld_p[DELAY-1];

    assign o_wb_ack  = r_vld_p[DELAY-1] && !r_err_p[DELAY-1];
    assign o_wb_err  = r_vld_p[DELAY-1] &&  r_err_p[DELAY-1];
    assign o_wb_data = r_vld_p[DELAY-1] ? r_dat_p[DELAY-1] : '0;

    // Control: valid chain and pending count; an abort behaves exactly like reset.
    always_ff @(posedge i_wb_clk) begin
        if (!i_reset_n || !i_wb_cyc) begin
            r_vld_p <= '0;
            r_pend  <= '0;
        end else begin
            r_vld_p[0] <= w_accept;
            for (int i = 1; i < DELAY; i++) begin
                r_vld_p[i] <= r_vld_p[i-1];
            end
            r_pend <= r_pend + PW'(w_accept) - PW'(w_retire);
        end
    end

    // Stage 0 captures the RAM word at acceptance; later stages only shift.
    always_ff @(posedge i_wb_clk) begin
        r_err_p[0] <= !w_in_range;
        r_dat_p[0] <= r_mem[w_idx];
        for (int i = 1; i < DELAY; i++) begin
            r_err_p[i] <= r_err_p[i-1];
            r_dat_p[i] <= r_dat_p[i-1];
        end
    end

    always_ff @(posedge i_wb_clk) begin
        if (w_accept && i_wb_we && w_in_range) begin
            for (int b = 0; b < NB; b++) begin
                if (i_wb_sel[b]) begin
                    r_mem[w_idx][8*b +: 8] <= i_wb_data[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_wbscratchpad.sv
// Bench for wbscratchpad: two instances (DELAY=2 and DELAY=4) each driven by its own
// request queue and checked every cycle against a transaction-level model.
module tb_wbscratchpad;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        cyc;
    logic        stb_i [2];
    logic        we_i  [2];
    logic [29:0] adr_i [2];
    logic [31:0] dat_i [2];
    logic [3:0]  sel_i [2];
    logic        stall_o [2];
    logic        ack_o   [2];
    logic        err_o   [2];
    logic [31:0] dat_o   [2];

    wbscratchpad #(.AW(30), .DW(32), .LGMEM(8), .DELAY(2), .MAXPEND(2)) u_d2 (
        .i_wb_clk(clk), .i_reset_n(rst_n), .i_wb_cyc(cyc), .i_wb_stb(stb_i[0]),
        .i_wb_we(we_i[0]), .i_wb_addr(adr_i[0]), .i_wb_data(dat_i[0]), .i_wb_sel(sel_i[0]),
        .o_wb_stall(stall_o[0]), .o_wb_ack(ack_o[0]), .o_wb_data(dat_o[0]), .o_wb_err(err_o[0])
    );

    wbscratchpad #(.AW(30), .DW(32), .LGMEM(8), .DELAY(4), .MAXPEND(2)) u_d4 (
        .i_wb_clk(clk), .i_reset_n(rst_n), .i_wb_cyc(cyc), .i_wb_stb(stb_i[1]),
        .i_wb_we(we_i[1]), .i_wb_addr(adr_i[1]), .i_wb_data(dat_i[1]), .i_wb_sel(sel_i[1]),
        .o_wb_stall(stall_o[1]), .o_wb_ack(ack_o[1]), .o_wb_data(dat_o[1]), .o_wb_err(err_o[1])
    );

    typedef struct {
        logic        we;
        logic [29:0] addr;
        logic [31:0] data;
        logic [3:0]  sel;
    } req_t;

    typedef struct {
        int          acc;
        bit          err;
        bit          rd;
        logic [31:0] data;
    } rsp_t;

    req_t        mq [2][$];
    rsp_t        rq [2][$];
    int          acc_e [2][$];
    int          ack_e [2][$];
    logic [31:0] mem_m [2][16];
    int          dl [2] = '{2, 4};
    int          mp [2] = '{2, 2};
    int          edge_n = 0;
    bit          started = 0;
    int          checks = 0;
    int          fails = 0;
    int          ack_cnt [2] = '{0, 0};
    int          err_cnt [2] = '{0, 0};
    logic [31:0] last_rd [2];
    int          gap_pct = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic req_t mk(bit we, logic [29:0] a, logic [31:0] d, logic [3:0] s);
        req_t r;
        r.we = we; r.addr = a; r.data = d; r.sel = s;
        return r;
    endfunction

    task automatic push_both(input req_t r);
        mq[0].push_back(r);
        mq[1].push_back(r);
    endtask

    function automatic logic [29:0] rand_addr();
        logic [29:0] a;
        if ($urandom_range(0, 3) == 0)
            a = 30'($urandom_range(0, 255)) | (30'(1) << $urandom_range(8, 29));
        else
            a = 30'($urandom_range(0, 15));
        return a;
    endfunction

    // One clock: present requests, check outputs against the model, advance the model.
    task automatic step();
        bit   acc [2];
        bit   ea;
        rsp_t h;
        rsp_t rs;
        req_t r;
        for (int k = 0; k < 2; k++) begin
            if (mq[k].size() > 0 && (gap_pct == 0 || $urandom_range(0, 99) >= gap_pct)) begin
                stb_i[k] = 1'b1;
                we_i[k]  = mq[k][0].we;
                adr_i[k] = mq[k][0].addr;
                dat_i[k] = mq[k][0].data;
                sel_i[k] = mq[k][0].sel;
            end else begin
                stb_i[k] = 1'b0;
            end
        end
        for (int k = 0; k < 2; k++) begin
            ea = 1'b0;
            if (rq[k].size() > 0) begin
                h  = rq[k][0];
                ea = (h.acc + dl[k] - 1 == edge_n);
            end
            if (started) begin
                chk($sformatf("d%0d_stall", dl[k]), 32'(stall_o[k]), 32'(rq[k].size() == mp[k]));
                chk($sformatf("d%0d_ack", dl[k]), 32'(ack_o[k]), 32'(ea && !h.err));
                chk($sformatf("d%0d_err", dl[k]), 32'(err_o[k]), 32'(ea && h.err));
                if (ea && !h.err && h.rd) begin
                    chk($sformatf("d%0d_rdata", dl[k]), dat_o[k], h.data);
                    last_rd[k] = dat_o[k];
                end
                if (ack_o[k] === 1'b1) begin
                    ack_cnt[k]++;
                    ack_e[k].push_back(edge_n);
                end
                if (err_o[k] === 1'b1) err_cnt[k]++;
            end
            acc[k] = rst_n && cyc && stb_i[k] && (rq[k].size() != mp[k]);
        end
        @(posedge clk);
        edge_n++;
        for (int k = 0; k < 2; k++) begin
            if (!rst_n || !cyc) begin
                rq[k].delete();
            end else begin
                if (rq[k].size() > 0 && rq[k][0].acc + dl[k] == edge_n) void'(rq[k].pop_front());
                if (acc[k]) begin
                    r = mq[k].pop_front();
                    rs.acc  = edge_n;
                    rs.err  = (r.addr >= 30'd256);
                    rs.rd   = !r.we;
                    rs.data = rs.err ? 32'h0 : mem_m[k][r.addr[3:0]];
                    rq[k].push_back(rs);
                    acc_e[k].push_back(edge_n);
                    if (r.we && !rs.err)
                        for (int b = 0; b < 4; b++)
                            if (r.sel[b]) mem_m[k][r.addr[3:0]][8*b +: 8] = r.data[8*b +: 8];
                end
            end
        end
        #1;
        started = 1'b1;
    endtask

    task automatic drain();
        for (int n = 0; n < 3000; n++) begin
            if (mq[0].size() + mq[1].size() + rq[0].size() + rq[1].size() == 0) break;
            step();
        end
        chk("drain_left", 32'(mq[0].size() + mq[1].size() + rq[0].size() + rq[1].size()), 32'd0);
    endtask

    task automatic clear_hist();
        for (int k = 0; k < 2; k++) begin
            acc_e[k].delete();
            ack_e[k].delete();
        end
    endtask

    initial begin
        int a0 [2];
        int e0 [2];
        rst_n = 1'b0;
        cyc   = 1'b1;
        for (int k = 0; k < 2; k++) begin
            stb_i[k] = 1'b0; we_i[k] = 1'b0; adr_i[k] = '0; dat_i[k] = '0; sel_i[k] = '0;
        end

        // reset held 3 clocks with a request on the bus
        push_both(mk(1'b1, 30'd0, 32'h1111_1111, 4'hF));
        for (int n = 0; n < 3; n++) begin
            step();
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("rst_ack%0d", k), 32'(ack_o[k]), 32'd0);
                chk($sformatf("rst_err%0d", k), 32'(err_o[k]), 32'd0);
                chk($sformatf("rst_stall%0d", k), 32'(stall_o[k]), 32'd0);
                chk($sformatf("rst_data%0d", k), dat_o[k], 32'd0);
            end
        end
        rst_n = 1'b1;

        for (int a = 0; a < 16; a++) push_both(mk(1'b1, 30'(a), $urandom, 4'hF));
        drain();

        // write then back-to-back read of the same word
        clear_hist();
        push_both(mk(1'b1, 30'd5, 32'hDEAD_BEEF, 4'hF));
        push_both(mk(1'b0, 30'd5, 32'h0, 4'hF));
        drain();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("lat_w_d%0d", dl[k]), 32'(ack_e[k][0] - acc_e[k][0]), 32'(dl[k] - 1));
            chk($sformatf("lat_r_d%0d", dl[k]), 32'(ack_e[k][1] - acc_e[k][0]), 32'(dl[k]));
            chk($sformatf("rd_beef_d%0d", dl[k]), last_rd[k], 32'hDEAD_BEEF);
        end

        // single byte lane update
        push_both(mk(1'b1, 30'd5, 32'h0000_AB00, 4'b0010));
        push_both(mk(1'b0, 30'd5, 32'h0, 4'hF));
        drain();
        for (int k = 0; k < 2; k++) chk($sformatf("rd_lane_d%0d", dl[k]), last_rd[k], 32'hDEAD_ABEF);

        // out-of-range write must error and not alias onto word 0
        for (int k = 0; k < 2; k++) begin a0[k] = ack_cnt[k]; e0[k] = err_cnt[k]; end
        push_both(mk(1'b1, 30'd0, 32'hCAFE_F00D, 4'hF));
        push_both(mk(1'b1, 30'd256, 32'h1234_5678, 4'hF));
        push_both(mk(1'b0, 30'd0, 32'h0, 4'hF));
        drain();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("oor_err_d%0d", dl[k]), 32'(err_cnt[k] - e0[k]), 32'd1);
            chk($sformatf("oor_ack_d%0d", dl[k]), 32'(ack_cnt[k] - a0[k]), 32'd2);
            chk($sformatf("oor_alias_d%0d", dl[k]), last_rd[k], 32'hCAFE_F00D);
        end

        // four back-to-back reads throttled by MAXPEND
        clear_hist();
        for (int k = 0; k < 2; k++) begin a0[k] = ack_cnt[k]; e0[k] = err_cnt[k]; end
        for (int a = 1; a <= 4; a++) push_both(mk(1'b0, 30'(a), 32'h0, 4'hF));
        drain();
        chk("thr_acc1", 32'(acc_e[1][1] - acc_e[1][0]), 32'd1);
        chk("thr_acc2", 32'(acc_e[1][2] - acc_e[1][0]), 32'd5);
        chk("thr_acc3", 32'(acc_e[1][3] - acc_e[1][0]), 32'd6);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("thr_acks_d%0d", dl[k]), 32'(ack_cnt[k] - a0[k]), 32'd4);
            chk($sformatf("thr_errs_d%0d", dl[k]), 32'(err_cnt[k] - e0[k]), 32'd0);
        end

        // abort with two reads outstanding
        push_both(mk(1'b0, 30'd6, 32'h0, 4'hF));
        push_both(mk(1'b0, 30'd7, 32'h0, 4'hF));
        step();
        step();
        cyc = 1'b0;
        step();
        cyc = 1'b1;
        for (int k = 0; k < 2; k++) begin
            a0[k] = ack_cnt[k]; e0[k] = err_cnt[k];
            chk($sformatf("abort_stall_d%0d", dl[k]), 32'(stall_o[k]), 32'd0);
        end
        for (int n = 0; n < 6; n++) step();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("abort_ack_d%0d", dl[k]), 32'(ack_cnt[k] - a0[k]), 32'd0);
            chk($sformatf("abort_err_d%0d", dl[k]), 32'(err_cnt[k] - e0[k]), 32'd0);
        end

        // randomized traffic with bus gaps
        gap_pct = 30;
        for (int n = 0; n < 250; n++) begin
            for (int k = 0; k < 2; k++)
                mq[k].push_back(mk(1'($urandom_range(0, 1)), rand_addr(), $urandom, 4'($urandom_range(0, 15))));
        end
        drain();
        gap_pct = 0;
        for (int n = 0; n < 4; n++) step();

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
